unidade_controle_mostra_sequencia: RTL and testbench

- Main FSM for the next version of the memory game: shows the current sequence on the LEDs, then collects and checks the player's moves.
- Each round has a growing limit. A per-move timeout ends the game if the player is too slow.
- Drives the existing datapath control inputs: address counter, limit counter and move register. Internal show/gap/timeout timers replace the datapath timer.
- Moore machine; the top level decodes db_estado to a 7-segment display.

---
 rtl/unidade_controle_mostra_sequencia.sv | 164 ++++++++++++++++
 tb/tb_unidade_controle_mostra_sequencia.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_mostra_sequencia.sv
// Memory-game control FSM: shows the sequence on the LEDs, then collects and checks each player move.
// Defining UNIDADE_CONTROLE_TIMEOUT_EN enables the per-move timeout path out of espera_jogada.
module unidade_controle_mostra_sequencia #(
  parameter int TEMPO_MOSTRA  = 1000,
  parameter int TEMPO_APAGADO = 250,
  parameter int TEMPO_TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       mostra_leds,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int TMAX_MA = (TEMPO_MOSTRA > TEMPO_APAGADO) ? TEMPO_MOSTRA : TEMPO_APAGADO;
  localparam int TMAX    = (TMAX_MA > TEMPO_TIMEOUT) ? TMAX_MA : TEMPO_TIMEOUT;
  localparam int TW      = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] LIM_MOSTRA  = TW'(TEMPO_MOSTRA - 1);
  localparam logic [TW-1:0] LIM_APAGADO = TW'(TEMPO_APAGADO - 1);
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  localparam logic [TW-1:0] LIM_TIMEOUT = TW'(TEMPO_TIMEOUT - 1);
`endif

  typedef enum logic [3:0] {
    INICIAL           = 4'h0,
    PREPARACAO        = 4'h1,
    INICIA_SEQUENCIA  = 4'h2,
    MOSTRA            = 4'h3,
    APAGA             = 4'h4,
    PROXIMO_MOSTRA    = 4'h5,
    ZERA_ENDERECOS    = 4'h6,
    ESPERA_JOGADA     = 4'h7,
    REGISTRA          = 4'h8,
    COMPARACAO        = 4'h9,
    PROXIMA_JOGADA    = 4'hA,
    PROXIMA_SEQUENCIA = 4'hB,
    FIM_ACERTOU       = 4'hC,
    FIM_ERROU         = 4'hD,
    FIM_TIMEOUT       = 4'hE
  } estado_t;

  typedef struct packed {
    logic zera_e;
    logic conta_e;
    logic zera_l;
    logic conta_l;
    logic zera_r;
    logic registra_r;
    logic mostra_leds;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  estado_t          estado_q, estado_d;
  logic [TW-1:0]    timer_q;
  saidas_t          saidas_q;
  logic             conta_tempo;

  // Outputs are registered from the next state, so they always match estado_q (pure Moore).
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARACAO:        begin s.zera_e = 1'b1; s.zera_l = 1'b1; s.zera_r = 1'b1; end
      INICIA_SEQUENCIA:  s.zera_e = 1'b1;
      MOSTRA:            s.mostra_leds = 1'b1;
      PROXIMO_MOSTRA:    s.conta_e = 1'b1;
      ZERA_ENDERECOS:    begin s.zera_e = 1'b1; s.zera_r = 1'b1; end
      REGISTRA:          s.registra_r = 1'b1;
      PROXIMA_JOGADA:    s.conta_e = 1'b1;
      PROXIMA_SEQUENCIA: s.conta_l = 1'b1;
      FIM_ACERTOU:       begin s.pronto = 1'b1; s.acertou = 1'b1; end
      FIM_ERROU:         begin s.pronto = 1'b1; s.errou = 1'b1; end
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
      FIM_TIMEOUT:       begin s.pronto = 1'b1; s.timeout = 1'b1; end
`else
      FIM_TIMEOUT:       s.pronto = 1'b1;
`endif
      default:           s = '0;
    endcase
    return s;
  endfunction

  assign conta_tempo = (estado_q == MOSTRA) || (estado_q == APAGA) || (estado_q == ESPERA_JOGADA);

  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:           estado_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:        estado_d = INICIA_SEQUENCIA;
      INICIA_SEQUENCIA:  estado_d = MOSTRA;
      MOSTRA:            estado_d = (timer_q == LIM_MOSTRA) ? APAGA : MOSTRA;
      APAGA: begin
        if (timer_q == LIM_APAGADO) estado_d = fimE ? ZERA_ENDERECOS : PROXIMO_MOSTRA;
        else                        estado_d = APAGA;
      end
      PROXIMO_MOSTRA:    estado_d = MOSTRA;
      ZERA_ENDERECOS:    estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada) estado_d = REGISTRA;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        else if (timer_q == LIM_TIMEOUT) estado_d = FIM_TIMEOUT;
`endif
        else estado_d = ESPERA_JOGADA;
      end
      REGISTRA:          estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)            estado_d = FIM_ERROU;
        else if (fimE && fimL) estado_d = FIM_ACERTOU;
        else if (fimE)         estado_d = PROXIMA_SEQUENCIA;
        else                   estado_d = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA:    estado_d = ESPERA_JOGADA;
      PROXIMA_SEQUENCIA: estado_d = INICIA_SEQUENCIA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: estado_d = iniciar ? PREPARACAO : estado_q;
      default:           estado_d = INICIAL;
    endcase
  end

  // The timer restarts on every state change, giving each phase and each move a full window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIAL;
      timer_q  <= '0;
      saidas_q <= '0;
    end else begin
      estado_q <= estado_d;
      saidas_q <= decodifica(estado_d);
      if (estado_d != estado_q) timer_q <= '0;
      else if (conta_tempo)     timer_q <= timer_q + 1'b1;
    end
  end

  assign zeraE       = saidas_q.zera_e;
  assign contaE      = saidas_q.conta_e;
  assign zeraL       = saidas_q.zera_l;
  assign contaL      = saidas_q.conta_l;
  assign zeraR       = saidas_q.zera_r;
  assign registraR   = saidas_q.registra_r;
  assign mostra_leds = saidas_q.mostra_leds;
  assign pronto      = saidas_q.pronto;
  assign acertou     = saidas_q.acertou;
  assign errou       = saidas_q.errou;
  assign timeout     = saidas_q.timeout;
  assign db_estado   = estado_q;

endmodule

// File: tb/tb_unidade_controle_mostra_sequencia.sv
// Bench for the memory-game control FSM: vector table, corner sequences, and closed-loop random games.
module tb_unidade_controle_mostra_sequencia;

  localparam int TM   = 4;
  localparam int TA   = 2;
  localparam int TT   = 10;
  localparam int LAST = 3;

  localparam logic [10:0] O_ZE = 11'h400, O_CE = 11'h200, O_ZL = 11'h100, O_CL = 11'h080;
  localparam logic [10:0] O_ZR = 11'h040, O_RR = 11'h020, O_ML = 11'h010, O_PR = 11'h008;
  localparam logic [10:0] O_AC = 11'h004, O_ER = 11'h002, O_TO = 11'h001;

  logic clock = 1'b0;
  logic reset, iniciar, jogada, igual, fimE, fimL;
  logic zeraE, contaE, zeraL, contaL, zeraR, registraR, mostra_leds, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  unidade_controle_mostra_sequencia #(.TEMPO_MOSTRA(TM), .TEMPO_APAGADO(TA), .TEMPO_TIMEOUT(TT)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .fimE(fimE), .fimL(fimL), .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .mostra_leds(mostra_leds), .pronto(pronto),
    .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );

  // Environment datapath: address/limit counters, sequence memory and move register.
  logic       use_dp = 1'b0;
  logic       tb_igual = 1'b0, tb_fimE = 1'b0, tb_fimL = 1'b0;
  logic [3:0] mem [16];
  logic [3:0] addr = '0, lim = '0, mov = '0, botoes = '0;

  always @(posedge clock) begin
    if (zeraE) addr <= '0; else if (contaE) addr <= addr + 4'd1;
    if (zeraL) lim <= '0;  else if (contaL) lim <= lim + 4'd1;
    if (zeraR) mov <= '0;  else if (registraR) mov <= botoes;
  end

  assign igual = use_dp ? (mov == mem[addr]) : tb_igual;
  assign fimE  = use_dp ? (addr == lim) : tb_fimE;
  assign fimL  = use_dp ? (lim == 4'(LAST)) : tb_fimL;

  logic [10:0] dut_outs;
  assign dut_outs = {zeraE, contaE, zeraL, contaL, zeraR, registraR, mostra_leds, pronto, acertou, errou, timeout};

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nome, $time, act, exp);
    end
  endtask

  task automatic ciclo(input logic ini, input logic jog, input logic igu, input logic fe, input logic fl);
    @(negedge clock);
    iniciar = ini; jogada = jog; tb_igual = igu; tb_fimE = fe; tb_fimL = fl;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; iniciar = 0; jogada = 0; tb_igual = 0; tb_fimE = 0; tb_fimL = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Reset, start, one-position show with fimE=1; returns at the first espera_jogada cycle.
  task automatic go_to_espera();
    do_reset();
    ciclo(1, 0, 0, 1, 0);
    repeat (10) ciclo(0, 0, 0, 1, 0);
    chk("entra_espera", db_estado, 4'h7);
  endtask

  typedef struct {
    logic ini, jog, igu, fe, fl;
    logic [3:0]  st;
    logic [10:0] outs;
  } vec_t;
  vec_t tab[$];

  task automatic add(input logic ini, jog, igu, fe, fl, input logic [3:0] st, input logic [10:0] outs);
    vec_t v;
    v.ini = ini; v.jog = jog; v.igu = igu; v.fe = fe; v.fl = fl; v.st = st; v.outs = outs;
    tab.push_back(v);
  endtask

  typedef struct {
    logic [3:0] st;
    logic       ini, jog;
    logic [3:0] mv;
  } cyc_t;
  cyc_t esp[$];

  task automatic push(input logic [3:0] st, input logic ini, input logic jog, input logic [3:0] mv);
    cyc_t c;
    c.st = st; c.ini = ini; c.jog = jog; c.mv = mv;
    esp.push_back(c);
  endtask

  // States that ignore both iniciar and jogada get random noise on them.
  task automatic push_ruido(input logic [3:0] st);
    push(st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
  endtask

  task automatic gen_jogo(input logic [3:0] inicio, output logic [3:0] fin);
    int r;
    int d;
    bit certo;
    fin = 4'h0;
    r = 0;
    push(inicio, 1'b1, 1'($urandom_range(0, 1)), 4'h0);
    push_ruido(4'h1);
    while (fin == 4'h0) begin
      push_ruido(4'h2);
      for (int i = 0; i <= r; i++) begin
        repeat (TM) push_ruido(4'h3);
        repeat (TA) push_ruido(4'h4);
        if (i < r) push_ruido(4'h5);
      end
      push_ruido(4'h6);
      for (int m = 0; m <= r && fin == 4'h0; m++) begin
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        d = $urandom_range(0, TT + 1);
`else
        d = $urandom_range(0, TT + 4);
`endif
        certo = ($urandom_range(0, 7) != 0);
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        if (d >= TT) begin
          repeat (TT) push(4'h7, 1'($urandom_range(0, 1)), 1'b0, 4'h0);
          fin = 4'hE;
          continue;
        end
`endif
        repeat (d) push(4'h7, 1'($urandom_range(0, 1)), 1'b0, 4'h0);
        push(4'h7, 1'($urandom_range(0, 1)), 1'b1,
             certo ? mem[m] : (mem[m] ^ 4'($urandom_range(1, 15))));
        push_ruido(4'h8);
        push_ruido(4'h9);
        if (!certo)         fin = 4'hD;
        else if (m < r)     push_ruido(4'hA);
        else if (r == LAST) fin = 4'hC;
        else                push_ruido(4'hB);
      end
      r++;
    end
    repeat ($urandom_range(1, 3)) push(fin, 1'b0, 1'($urandom_range(0, 1)), 4'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] fin;
    reset = 1'b1; iniciar = 0; jogada = 0;
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);

    // ---- vector table: two rounds then a wrong move ----
    add(1,0,0,0,0, 4'h0, 11'h0);
    add(0,0,0,0,0, 4'h1, O_ZE|O_ZL|O_ZR);
    add(0,0,0,0,0, 4'h2, O_ZE);
    repeat (4) add(0,0,0,0,0, 4'h3, O_ML);
    repeat (2) add(0,0,0,0,0, 4'h4, 11'h0);
    add(0,0,0,0,0, 4'h5, O_CE);
    repeat (4) add(0,1,0,0,0, 4'h3, O_ML);
    repeat (2) add(0,0,0,1,0, 4'h4, 11'h0);
    add(0,0,0,1,0, 4'h6, O_ZE|O_ZR);
    add(0,1,1,1,0, 4'h7, 11'h0);
    add(0,0,1,1,0, 4'h8, O_RR);
    add(0,0,1,1,0, 4'h9, 11'h0);
    add(0,0,0,0,0, 4'hB, O_CL);
    add(0,0,0,0,0, 4'h2, O_ZE);
    repeat (4) add(0,0,0,0,0, 4'h3, O_ML);
    repeat (2) add(0,0,0,1,0, 4'h4, 11'h0);
    add(0,0,0,1,0, 4'h6, O_ZE|O_ZR);
    add(0,1,0,1,0, 4'h7, 11'h0);
    add(0,0,0,1,0, 4'h8, O_RR);
    add(0,0,0,1,0, 4'h9, 11'h0);
    add(0,1,0,0,0, 4'hD, O_PR|O_ER);
    add(1,0,0,0,0, 4'hD, O_PR|O_ER);
    add(0,0,0,0,0, 4'h1, O_ZE|O_ZL|O_ZR);

    do_reset();
    foreach (tab[i]) begin
      @(negedge clock);
      chk($sformatf("tab%0d_estado", i), db_estado, tab[i].st);
      chk($sformatf("tab%0d_saidas", i), dut_outs, tab[i].outs);
      iniciar = tab[i].ini; jogada = tab[i].jog; tb_igual = tab[i].igu;
      tb_fimE = tab[i].fe; tb_fimL = tab[i].fl;
    end

    // ---- timeout window boundary ----
    go_to_espera();
    repeat (9) ciclo(0, 0, 0, 1, 0);
    chk("espera_ciclo10", db_estado, 4'h7);
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    ciclo(0, 0, 0, 1, 0);
    chk("timeout_estado", db_estado, 4'hE);
    chk("timeout_saidas", dut_outs, O_PR|O_TO);
`else
    repeat (41) ciclo(0, 0, 0, 1, 0);
    chk("sem_timeout_estado", db_estado, 4'h7);
    chk("sem_timeout_flag", timeout, 1'b0);
`endif

    // ---- jogada in the 10th cycle wins, then a full win ----
    go_to_espera();
    repeat (9) ciclo(0, 0, 0, 1, 0);
    jogada = 1'b1;
    ciclo(0, 0, 1, 1, 1);
    chk("jogada_ultimo_ciclo", db_estado, 4'h8);
    chk("jogada_sem_timeout", timeout, 1'b0);
    ciclo(0, 0, 1, 1, 1);
    chk("comparacao", db_estado, 4'h9);
    ciclo(0, 1, 1, 1, 1);
    chk("acertou_estado", db_estado, 4'hC);
    chk("acertou_saidas", dut_outs, O_PR|O_AC);
    repeat (3) ciclo(0, 1, 0, 0, 0);
    chk("acertou_mantem", db_estado, 4'hC);
    iniciar = 1'b1;
    ciclo(0, 0, 0, 0, 0);
    chk("reinicia", db_estado, 4'h1);

    // ---- proxima_jogada restarts the move window ----
    go_to_espera();
    jogada = 1'b1;
    ciclo(0, 0, 1, 0, 0);
    ciclo(0, 0, 1, 0, 0);
    chk("cmp_prox", db_estado, 4'h9);
    ciclo(0, 0, 0, 0, 0);
    chk("proxima_jogada", dut_outs, O_CE);
    chk("proxima_jogada_estado", db_estado, 4'hA);
    repeat (10) ciclo(0, 0, 0, 0, 0);
    chk("nova_janela", db_estado, 4'h7);

    // ---- asynchronous reset mid-show ----
    do_reset();
    ciclo(1, 0, 0, 0, 0);
    repeat (4) ciclo(0, 0, 0, 0, 0);
    chk("mostra_antes_reset", mostra_leds, 1'b1);
    reset = 1'b1;
    #1;
    chk("reset_async_estado", db_estado, 4'h0);
    chk("reset_async_leds", mostra_leds, 1'b0);
    reset = 1'b0;

    // ---- closed-loop random games against the game-rule model ----
    fin = 4'h0;
    for (int g = 0; g < 20; g++) gen_jogo(fin, fin);
    use_dp = 1'b1;
    do_reset();
    foreach (esp[c]) begin
      if (errors > 40) break;
      @(negedge clock);
      chk($sformatf("jogo_estado%0d", c), db_estado, esp[c].st);
      chk($sformatf("jogo_leds%0d", c), mostra_leds, esp[c].st == 4'h3);
      chk($sformatf("jogo_flags%0d", c), {pronto, acertou, errou, timeout},
          esp[c].st == 4'hC ? 4'b1100 : esp[c].st == 4'hD ? 4'b1010 :
          esp[c].st == 4'hE ? 4'b1001 : 4'b0000);
      iniciar = esp[c].ini;
      jogada  = esp[c].jog;
      if (esp[c].st == 4'h7 && esp[c].jog) botoes = esp[c].mv;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
